// File: rtl/mc_pkg.sv
// Shared types and defaults for the memory-controller request path.
package mc_pkg;

   localparam int MC_ADDR_W          = 33;
   localparam int MC_DEFAULT_DEPTH   = 16;
   localparam int MC_DEFAULT_LATENCY = 100;

   typedef enum logic [1:0] {
      READ   = 2'd0,
      WRITE  = 2'd1,
      IFETCH = 2'd2
   } op_e;

   typedef struct packed {
      op_e                  op;
      logic [MC_ADDR_W-1:0] addr;
   } req_t;

endpackage

// File: rtl/mc_slot_timer.sv
// Per-slot service timer: loadable down-counter that saturates at zero.
module mc_slot_timer #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mc_req_queue.sv
// Latency-holding request queue between the request front end and the DRAM scheduler.
// Optional occupancy/stall statistics are enabled with MC_REQ_QUEUE_STATS_EN.
module mc_req_queue
   import mc_pkg::*;
#(
   parameter int DEPTH   = MC_DEFAULT_DEPTH,
   parameter int LATENCY = MC_DEFAULT_LATENCY,
   parameter int ADDR_W  = MC_ADDR_W,
   parameter int OP_W    = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [OP_W-1:0]              in_op,
   input  logic [ADDR_W-1:0]            in_addr,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OP_W-1:0]              out_op,
   output logic [ADDR_W-1:0]            out_addr,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
`ifdef MC_REQ_QUEUE_STATS_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0]   hwm,
   output logic [31:0]                  stall_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int TMR_W = $clog2(LATENCY+1);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(LATENCY);

   logic [OP_W-1:0]   op_mem   [DEPTH];
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count_nxt;
   logic [DEPTH-1:0]  slot_load;
   logic [DEPTH-1:0]  slot_zero;
   logic              enq;
   logic              deq;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign in_ready  = !full;
   assign enq       = in_valid && in_ready;
   assign out_valid = !empty && slot_zero[rd_ptr];
   assign deq       = out_valid && out_ready;

   // Gating on empty keeps the head outputs at zero after reset instead of stale slot data.
   assign out_op    = empty ? '0 : op_mem[rd_ptr];
   assign out_addr  = empty ? '0 : addr_mem[rd_ptr];

   always_comb begin
      slot_load = '0;
      if (enq) begin
         slot_load[wr_ptr] = 1'b1;
      end
   end

   always_comb begin
      count_nxt = count;
      if (enq && !deq) begin
         count_nxt = count + CNT_W'(1);
      end else if (deq && !enq) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      mc_slot_timer #(
         .W        (TMR_W)
      ) u_timer (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (slot_load[g]),
         .load_val (LOAD_VAL),
         .zero     (slot_zero[g])
      );
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         op_mem[wr_ptr]   <= in_op;
         addr_mem[wr_ptr] <= in_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (deq) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
         end
         count <= count_nxt;
      end
   end

`ifdef MC_REQ_QUEUE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hwm       <= '0;
         stall_cnt <= '0;
      end else begin
         if (count_nxt > hwm) begin
            hwm <= count_nxt;
         end
         if (in_valid && !in_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
